// File: rtl/ctrl_sel_filtro_pkg.sv
// ============================================================================
// ctrl_sel_filtro_pkg : shared encodings for the equalizer band-select control
// Rev 1.0
// ============================================================================
`default_nettype none

package ctrl_sel_filtro_pkg;

    localparam logic [1:0] CASO_BAJOS  = 2'b00;
    localparam logic [1:0] CASO_MEDIOS = 2'b01;
    localparam logic [1:0] CASO_ALTOS  = 2'b10;
    localparam logic [1:0] CASO_TOTAL  = 2'b11;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        BAJA   = 2'd1,
        SUBE   = 2'd2
    } estado_t;

    typedef enum logic {
        DIR_SIG = 1'b0,
        DIR_ANT = 1'b1
    } dir_t;

    // Modulo-4 step of the select, wrapping in both directions
    function automatic logic [1:0] caso_siguiente(input logic [1:0] caso, input dir_t dir);
        return (dir == DIR_SIG) ? caso + 2'd1 : caso - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_sel_filtro_antirrebote.sv
// ============================================================================
// ctrl_sel_filtro_antirrebote : 2-FF synchronizer, debounce, rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_sel_filtro_antirrebote
    import ctrl_sel_filtro_pkg::*;
#(
    parameter int DEB_CICLOS = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic boton,
    output logic pulso
);

    localparam int CW = $clog2(DEB_CICLOS + 1);
    localparam logic [CW-1:0] C_DEB_FIN = CW'(DEB_CICLOS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_nivel;
    logic          r_estable;
    logic          r_estable_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_nivel     <= 1'b0;
            r_estable   <= 1'b0;
            r_estable_d <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync1     <= boton;
            r_sync2     <= r_sync1;
            r_nivel     <= r_sync2;
            r_estable_d <= r_estable;
            // Any movement of the synchronized level restarts the stability window
            if (r_sync2 != r_nivel) begin
                r_cnt <= '0;
            end else if (r_cnt == C_DEB_FIN) begin
                r_estable <= r_nivel;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign pulso = r_estable & ~r_estable_d;

endmodule

`default_nettype wire

// File: rtl/ctrl_sel_filtro.sv
// ============================================================================
// ctrl_sel_filtro : debounced next/prev select of the EQ output mux with a
// click-free mute around each change. Optional macro: FILTRO_AUTOSCAN_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_sel_filtro
    import ctrl_sel_filtro_pkg::*;
#(
    parameter int         DEB_CICLOS    = 500000,
    parameter int         MUTE_MUESTRAS = 4,
    parameter logic [1:0] CASO_RESET    = 2'b11,
    parameter int         AUTO_MUESTRAS = 96000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_sig,
    input  logic       btn_ant,
    input  logic       tick_muestra,
    output logic [1:0] caso,
    output logic       mute,
    output logic       cambio,
    output logic       ocupado
);

    localparam int TW = $clog2(MUTE_MUESTRAS + 1);
    localparam logic [TW-1:0] C_MUTE_FIN = TW'(MUTE_MUESTRAS - 1);

    if (MUTE_MUESTRAS < 1) begin : g_mute_invalido
        $error("MUTE_MUESTRAS must be at least 1");
    end
    if (AUTO_MUESTRAS < 1) begin : g_auto_invalido
        $error("AUTO_MUESTRAS must be at least 1");
    end

    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [TW-1:0] r_ticks;
    logic [1:0]    r_caso;
    logic          r_cambio;
    dir_t          r_dir;
    logic          r_pend;
    dir_t          r_pend_dir;

    logic w_req_sig;
    logic w_req_ant;
    logic w_btn_req;
    dir_t w_btn_dir;
    logic w_auto_req;
    logic w_req;
    dir_t w_dir;
    logic w_fin;

    ctrl_sel_filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_sig (
        .clk     (clk),
        .reset_n (reset_n),
        .boton   (btn_sig),
        .pulso   (w_req_sig)
    );

    ctrl_sel_filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb_ant (
        .clk     (clk),
        .reset_n (reset_n),
        .boton   (btn_ant),
        .pulso   (w_req_ant)
    );

    // Opposing requests in the same cycle cancel out
    assign w_btn_req = w_req_sig ^ w_req_ant;
    assign w_btn_dir = w_req_sig ? DIR_SIG : DIR_ANT;

`ifdef FILTRO_AUTOSCAN_EN
    localparam int AW = $clog2(AUTO_MUESTRAS + 1);
    localparam logic [AW-1:0] C_AUTO_FIN = AW'(AUTO_MUESTRAS - 1);

    logic [AW-1:0] r_inact;
    logic          w_inact_tick;

    assign w_inact_tick = (r_estado == ESPERA) && !w_btn_req && !r_pend && tick_muestra;
    assign w_auto_req   = w_inact_tick && (r_inact == C_AUTO_FIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inact <= '0;
        end else if (w_btn_req || w_auto_req) begin
            r_inact <= '0;
        end else if (w_inact_tick) begin
            r_inact <= r_inact + AW'(1);
        end
    end
`else
    assign w_auto_req = 1'b0;
`endif

    assign w_req = w_btn_req | w_auto_req;
    assign w_dir = w_btn_req ? w_btn_dir : DIR_SIG;
    assign w_fin = tick_muestra && (r_ticks == C_MUTE_FIN);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_estado   <= ESPERA;
            r_ticks    <= '0;
            r_caso     <= CASO_RESET;
            r_cambio   <= 1'b0;
            r_dir      <= DIR_SIG;
            r_pend     <= 1'b0;
            r_pend_dir <= DIR_SIG;
        end else begin
            r_estado <= w_estado_sig;
            r_cambio <= 1'b0;
            case (r_estado)
                ESPERA: begin
                    r_ticks <= '0;
                    if (w_req) begin
                        r_dir  <= w_dir;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_dir  <= r_pend_dir;
                        r_pend <= 1'b0;
                    end
                end
                BAJA, SUBE: begin
                    // Only the newest request survives a busy period
                    if (w_req) begin
                        r_pend     <= 1'b1;
                        r_pend_dir <= w_dir;
                    end
                    if (tick_muestra) begin
                        r_ticks <= w_fin ? '0 : r_ticks + TW'(1);
                    end
                    if ((r_estado == BAJA) && w_fin) begin
                        r_caso   <= caso_siguiente(r_caso, r_dir);
                        r_cambio <= 1'b1;
                    end
                end
                default: r_ticks <= '0;
            endcase
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            ESPERA:  if (w_req || r_pend) w_estado_sig = BAJA;
            BAJA:    if (w_fin)           w_estado_sig = SUBE;
            SUBE:    if (w_fin)           w_estado_sig = ESPERA;
            default:                      w_estado_sig = ESPERA;
        endcase
    end

    always_comb begin
        caso    = r_caso;
        cambio  = r_cambio;
        mute    = 1'b0;
        ocupado = 1'b0;
        if (r_estado != ESPERA) begin
            mute    = 1'b1;
            ocupado = 1'b1;
        end
    end

endmodule

`default_nettype wire
